// File: rtl/sqrt_pipe.sv
// Pipelined fixed-point square root. Each stage runs one restoring digit-recurrence step.
// The whole pipeline advances or stalls together under out_ready backpressure.
module sqrt_pipe #(
  parameter int WIDTH  = 16,
  parameter int FBITS  = 8,
  parameter int ROUND  = 0,
  parameter int SIGNED = 0,
  parameter int TAG_W  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] rad,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] root,
  output logic [WIDTH-1:0] rem,
  output logic             neg,
  output logic [TAG_W-1:0] out_tag
);
  localparam int ITER = (WIDTH + FBITS) / 2;
  localparam int XW   = WIDTH + FBITS;
  localparam int AW   = WIDTH + 2;
  localparam int XTOT = (ITER - 1) * ITER;

  typedef struct packed {
    logic [AW-1:0]    acc;
    logic [WIDTH-1:0] q;
  } rq_t;

  function automatic rq_t step(input logic [AW-1:0] acc, input logic [WIDTH-1:0] q,
                               input logic [1:0] b);
    rq_t r;
    logic [AW-1:0] a, t;
    a = (acc << 2) | AW'(b);
    t = (AW'(q) << 2) | AW'(1);
    if (a >= t) begin
      r.acc = a - t;
      r.q   = (q << 1) | WIDTH'(1);
    end else begin
      r.acc = a;
      r.q   = q << 1;
    end
    return r;
  endfunction

  // Stage k keeps only the XW-2k radicand bits still to be consumed, packed back to back.
  function automatic int xoff(input int k);
    return (k - 1) * XW - k * (k - 1);
  endfunction

  logic [ITER:1]                vld_d, vld_q;
  logic [XTOT-1:0]              xs_d, xs_q;
  logic [ITER-1:1][AW-1:0]      acc_d, acc_q;
  logic [ITER-1:1][WIDTH-1:0]   q_d, q_q;
  logic [ITER-1:1]              neg_d, neg_q;
  logic [ITER-1:1][TAG_W-1:0]   tag_d, tag_q;
  logic [WIDTH-1:0]             root_d, root_q, rem_d, rem_q;
  logic                         out_neg_d, out_neg_q;
  logic [TAG_W-1:0]             out_tag_d, out_tag_q;
  logic [XW-1:0]                x_head;
  logic                         neg_head;
  rq_t                          fin;

  always_comb begin
    x_head   = XW'(rad) << FBITS;
    neg_head = (SIGNED != 0) && rad[WIDTH-1];
    vld_d    = {vld_q[ITER-1:1], in_valid};
  end

  for (genvar k = 1; k < ITER; k++) begin : g_stg
    localparam int XR = XW - 2 * k;
    logic [XR+1:0]      x_in;
    logic [AW-1:0]      acc_in;
    logic [WIDTH-1:0]   q_in;
    logic               neg_in;
    logic [TAG_W-1:0]   tag_in;
    rq_t                r;
    if (k == 1) begin : g_first
      assign x_in   = x_head;
      assign acc_in = '0;
      assign q_in   = '0;
      assign neg_in = neg_head;
      assign tag_in = in_tag;
    end else begin : g_next
      assign x_in   = xs_q[xoff(k-1) +: XR+2];
      assign acc_in = acc_q[k-1];
      assign q_in   = q_q[k-1];
      assign neg_in = neg_q[k-1];
      assign tag_in = tag_q[k-1];
    end
    assign r                  = step(acc_in, q_in, x_in[XR+1 -: 2]);
    assign xs_d[xoff(k) +: XR] = x_in[XR-1:0];
    assign acc_d[k]           = r.acc;
    assign q_d[k]             = r.q;
    assign neg_d[k]           = neg_in;
    assign tag_d[k]           = tag_in;
  end

  // Last iteration folds in rounding and the negative-radicand override before the output flops.
  always_comb begin
    fin       = step(acc_q[ITER-1], q_q[ITER-1], xs_q[xoff(ITER-1) +: 2]);
    root_d    = fin.q;
    if (ROUND != 0 && fin.acc > AW'(fin.q)) root_d = fin.q + WIDTH'(1);
    rem_d     = WIDTH'(fin.acc);
    out_neg_d = neg_q[ITER-1];
    out_tag_d = tag_q[ITER-1];
    if (neg_q[ITER-1]) begin
      root_d = '0;
      rem_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)         vld_q <= '0;
    else if (in_ready) vld_q <= vld_d;
    if (in_ready) begin
      xs_q      <= xs_d;
      acc_q     <= acc_d;
      q_q       <= q_d;
      neg_q     <= neg_d;
      tag_q     <= tag_d;
      root_q    <= root_d;
      rem_q     <= rem_d;
      out_neg_q <= out_neg_d;
      out_tag_q <= out_tag_d;
    end
  end

  assign out_valid = vld_q[ITER];
  assign in_ready  = !(out_valid && !out_ready);
  assign root      = root_q;
  assign rem       = rem_q;
  assign neg       = out_neg_q;
  assign out_tag   = out_tag_q;
endmodule

// File: doc/sqrt_pipe.md
SQRT_PIPE -- requirements
Module: sqrt_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 16, radicand/root/remainder width in bits.
REQ-002 SHALL have parameter FBITS, default 8, fractional bits of the fixed-point radicand and root; legal range 0 <= FBITS < WIDTH with WIDTH+FBITS even.
REQ-003 SHALL have parameter ROUND, default 0; 0 = truncate root, 1 = round root to nearest.
REQ-004 SHALL have parameter SIGNED, default 0; 1 = radicand is two's complement and a negative radicand is flagged.
REQ-005 SHALL have parameter TAG_W, default 4, width of the sideband tag carried with each operand.
REQ-006 SHALL derive localparam ITER = (WIDTH+FBITS)/2, the pipeline depth.
REQ-007 clk  input  1  single clock; all state updates on its rising edge.
REQ-008 reset  input  1  synchronous, active-high reset.
REQ-009 in_valid  input  1  operand present on rad/in_tag.
REQ-010 in_ready  output  1  block accepts an operand this cycle.
REQ-011 rad  input  WIDTH  radicand.
REQ-012 in_tag  input  TAG_W  sideband tag, returned unchanged with the result.
REQ-013 out_valid  output  1  result present on root/rem/neg/out_tag.
REQ-014 out_ready  input  1  consumer accepts the result this cycle.
REQ-015 root  output  WIDTH  square root, same Q format as rad.
REQ-016 rem  output  WIDTH  truncation remainder (rad*2^FBITS - trunc_root^2).
REQ-017 neg  output  1  radicand was negative (SIGNED=1 only; otherwise constant 0).
REQ-018 out_tag  output  TAG_W  tag of the operand that produced this result.

Function
REQ-019 SHALL implement ITER stages, each stage performing exactly one restoring digit-recurrence iteration (2 radicand bits consumed, 1 root bit produced, accumulator WIDTH+2 bits wide).
REQ-020 SHALL accept an operand on any cycle where in_valid && in_ready; no operand is accepted otherwise.
REQ-021 in_ready SHALL equal !(out_valid && !out_ready): the pipeline advances as a unit and stalls as a unit.
REQ-022 With no stall, an operand accepted at edge N SHALL appear with out_valid=1 after edge N+ITER-1, i.e. latency ITER cycles; throughput one result per cycle.
REQ-023 While stalled, every stage register including valid bits, tags, and outputs SHALL hold its value; no bubble is inserted and no operand is lost or duplicated.
REQ-024 Bubbles (in_valid=0) SHALL propagate as invalid stages; results SHALL leave in acceptance order.
REQ-025 ROUND=0: root SHALL equal floor(sqrt(rad*2^FBITS)).
REQ-026 ROUND=1: root SHALL equal the truncated root plus 1 when rem > truncated root, else the truncated root; rem SHALL remain the truncation remainder.
REQ-027 SIGNED=1 and rad[WIDTH-1]=1: the result SHALL be root=0, rem=0, neg=1 at the normal latency position; SIGNED=0 treats rad as unsigned.
REQ-028 rad=0 SHALL give root=0, rem=0, neg=0; rad all-ones (SIGNED=0) SHALL give the correct maximal root without overflow.
REQ-029 Simultaneous accept at input and retire at output in one cycle SHALL both take effect.
REQ-030 root/rem/neg/out_tag SHALL be don't-care while out_valid=0.

Reset
REQ-031 reset=1 SHALL clear every stage valid bit, so out_valid=0 and in_ready=1 on the cycle after reset; data registers need not be cleared.
REQ-032 reset asserted mid-stream SHALL discard all in-flight operands; no result from before reset SHALL appear afterwards.
REQ-033 in_valid SHALL be ignored in any cycle where reset=1.

Verification (WIDTH=16, FBITS=8, ITER=12, TAG_W=4)
REQ-034 ROUND=0: rad=0xE890 (232.5625), tag=3 -> 12 cycles later root=0x0F40 (15.25), rem=0x0000, tag=3.
REQ-035 ROUND=0: back-to-back rad=0x0040, 0x0200, out_ready=1 -> consecutive results root=0x0080 (0.5), then root=0x016A with rem=0x001C.
REQ-036 rad=0x0003: with ROUND=0 -> root=0x001B, rem=0x0027; with ROUND=1 -> root=0x001C, rem=0x0027.
REQ-037 SIGNED=1: rad=0x8000 -> root=0, rem=0, neg=1; the next operand rad=0x0100 -> root=0x0100, neg=0.
REQ-038 Stream 20 random operands with out_ready toggled pseudo-randomly -> every result matches the reference model, in order, tags intact, and in_ready=0 exactly during stall cycles.
REQ-039 Fill the pipeline with 6 operands, assert reset for 1 cycle -> out_valid stays 0 until a new operand is accepted, and it emerges 12 cycles later.
